animated_sprite_object: RTL and testbench

//  Parametrised, multi-frame successor of the single-bitmap sprite drawers in the VGA path.
//  Per pixel, decides whether the sprite covers (oCoord_X, oCoord_Y).

---
 rtl/animated_sprite_object.sv | 133 +++++++++++++
 tb/tb_animated_sprite_object.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/animated_sprite_object.sv
// Multi-frame sprite drawer: hit test, scaled/flipped ROM addressing, colour-key transparency
// and an animation sequencer, with positions latched at start of frame.
module animated_sprite_object #(
  parameter int unsigned OBJ_W       = 32,
  parameter int unsigned OBJ_H       = 32,
  parameter int unsigned NUM_FRAMES  = 4,
  parameter int unsigned FRAME_TICKS = 8,
  parameter int unsigned SCALE_LOG2  = 0,
  parameter logic [7:0]  TRANSP_KEY  = 8'hFF,
  parameter int unsigned COORD_W     = 11,
  localparam int unsigned ADDR_W     = $clog2(NUM_FRAMES * OBJ_W * OBJ_H),
  localparam int unsigned FIDX_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic [COORD_W-1:0] oCoord_X,
  input  logic [COORD_W-1:0] oCoord_Y,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] ObjectStartX,
  input  logic [COORD_W-1:0] ObjectStartY,
  input  logic               flip_h,
  input  logic               anim_en,
  input  logic               loop_mode,
  input  logic               restart,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [7:0]         rom_data,
  output logic               drawing_request,
  output logic [7:0]         mVGA_RGB,
  output logic [FIDX_W-1:0]  frame_idx,
  output logic               anim_done
);

  localparam int unsigned CW1    = COORD_W + 1;
  localparam int unsigned TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CW1-1:0] BoxW = CW1'(OBJ_W << SCALE_LOG2);
  localparam logic [CW1-1:0] BoxH = CW1'(OBJ_H << SCALE_LOG2);

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  state_e              state;
  logic [TICK_W-1:0]   tick;
  logic [COORD_W-1:0]  pos_x, pos_y;
  logic                flip_q;
  logic                hit, hit_d1;
  logic [CW1-1:0]      x_ext, y_ext, px_ext, py_ext, rel_x, rel_y;
  logic [ADDR_W-1:0]   lx, ly, lx_eff, addr;

  // Position and flip only change at frame boundaries so a sprite is never torn.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      pos_x  <= '0;
      pos_y  <= '0;
      flip_q <= 1'b0;
    end else if (startOfFrame) begin
      pos_x  <= ObjectStartX;
      pos_y  <= ObjectStartY;
      flip_q <= flip_h;
    end
  end

  // One extra bit keeps the box end from wrapping near the right/bottom screen edge.
  always_comb begin
    x_ext  = {1'b0, oCoord_X};
    y_ext  = {1'b0, oCoord_Y};
    px_ext = {1'b0, pos_x};
    py_ext = {1'b0, pos_y};
    hit    = (x_ext >= px_ext) && (x_ext < px_ext + BoxW) &&
             (y_ext >= py_ext) && (y_ext < py_ext + BoxH);
    rel_x  = x_ext - px_ext;
    rel_y  = y_ext - py_ext;
    lx     = ADDR_W'(rel_x >> SCALE_LOG2);
    ly     = ADDR_W'(rel_y >> SCALE_LOG2);
    lx_eff = flip_q ? (ADDR_W'(OBJ_W - 1) - lx) : lx;
    addr   = ADDR_W'(frame_idx) * ADDR_W'(OBJ_W * OBJ_H) + ly * ADDR_W'(OBJ_W) + lx_eff;
    rom_addr = hit ? addr : '0;
  end

  // hit_d1 lines up with rom_data, which arrives one cycle after rom_addr.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      hit_d1          <= 1'b0;
      drawing_request <= 1'b0;
      mVGA_RGB        <= 8'h00;
    end else begin
      hit_d1          <= hit;
      drawing_request <= hit_d1 && (rom_data != TRANSP_KEY);
      mVGA_RGB        <= hit_d1 ? rom_data : 8'h00;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= StIdle;
      frame_idx <= '0;
      tick      <= '0;
      anim_done <= 1'b0;
    end else if (restart) begin
      state     <= StPlay;
      frame_idx <= '0;
      tick      <= '0;
      anim_done <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          frame_idx <= '0;
          if (anim_en) state <= StPlay;
        end
        StPlay: begin
          if (startOfFrame && anim_en) begin
            if (tick == TICK_W'(FRAME_TICKS - 1)) begin
              tick <= '0;
              if (frame_idx == FIDX_W'(NUM_FRAMES - 1)) begin
                if (loop_mode) begin
                  frame_idx <= '0;
                end else begin
                  state     <= StDone;
                  anim_done <= 1'b1;
                end
              end else begin
                frame_idx <= frame_idx + FIDX_W'(1);
              end
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end
        end
        StDone: anim_done <= 1'b1;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_animated_sprite_object.sv
// Bench for animated_sprite_object: two scale variants share stimulus, checked each cycle
// against a geometric/animation model plus literal pixel and frame expectations.
module tb_animated_sprite_object;

  localparam int OW = 32, OH = 32, NF = 4, FT = 8;

  logic        CLK = 1'b0, RESETn = 1'b0;
  logic [10:0] x = '0, y = '0, sx = '0, sy = '0;
  logic        sof = 1'b0, flip = 1'b0, en = 1'b0, loopm = 1'b0, rst_pulse = 1'b0;
  logic [11:0] addr0, addr1;
  logic [7:0]  rd0, rd1, rgb0, rgb1;
  logic        req0, req1, done0, done1;
  logic [1:0]  fi0, fi1;
  int          errors = 0, checks = 0;
  bit          chk_en = 1'b0;

  always #5 CLK = ~CLK;

  animated_sprite_object #(.SCALE_LOG2(0)) dut0 (
    .CLK(CLK), .RESETn(RESETn), .oCoord_X(x), .oCoord_Y(y), .startOfFrame(sof),
    .ObjectStartX(sx), .ObjectStartY(sy), .flip_h(flip), .anim_en(en), .loop_mode(loopm),
    .restart(rst_pulse), .rom_addr(addr0), .rom_data(rd0), .drawing_request(req0),
    .mVGA_RGB(rgb0), .frame_idx(fi0), .anim_done(done0)
  );

  animated_sprite_object #(.SCALE_LOG2(1)) dut1 (
    .CLK(CLK), .RESETn(RESETn), .oCoord_X(x), .oCoord_Y(y), .startOfFrame(sof),
    .ObjectStartX(sx), .ObjectStartY(sy), .flip_h(flip), .anim_en(en), .loop_mode(loopm),
    .restart(rst_pulse), .rom_addr(addr1), .rom_data(rd1), .drawing_request(req1),
    .mVGA_RGB(rgb1), .frame_idx(fi1), .anim_done(done1)
  );

  // ROM image: every address with a%8==5 is the transparent key, others never are.
  function automatic logic [7:0] color(input int a);
    if (a % 8 == 5) return 8'hFF;
    return 8'(a % 250 + 1);
  endfunction

  always @(posedge CLK) begin
    rd0 <= color(int'(addr0));
    rd1 <= color(int'(addr1));
  end

  // Model state
  int       m_px = 0, m_py = 0, m_frame = 0, m_tick = 0;
  bit       m_flip = 0, m_play = 0, m_done = 0;
  bit       p_hit [2];
  int       p_addr[2];
  bit       e_req [2];
  bit [7:0] e_rgb [2];

  function automatic void geom(input int s, output bit h, output int a);
    int xi, yi, lx, ly;
    xi = int'(x);
    yi = int'(y);
    h  = xi >= m_px && xi < m_px + (OW << s) && yi >= m_py && yi < m_py + (OH << s);
    lx = (xi - m_px) >> s;
    ly = (yi - m_py) >> s;
    if (m_flip) lx = OW - 1 - lx;
    a = h ? (m_frame * OW * OH + ly * OW + lx) : 0;
  endfunction

  always @(posedge CLK or negedge RESETn) begin
    bit h;
    int a;
    if (!RESETn) begin
      m_px <= 0; m_py <= 0; m_flip <= 0; m_frame <= 0; m_tick <= 0;
      m_play <= 0; m_done <= 0;
      for (int s = 0; s < 2; s++) begin
        p_hit[s] <= 0; p_addr[s] <= 0; e_req[s] <= 0; e_rgb[s] <= 8'h00;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        e_req[s] <= p_hit[s] && color(p_addr[s]) != 8'hFF;
        e_rgb[s] <= p_hit[s] ? color(p_addr[s]) : 8'h00;
        geom(s, h, a);
        p_hit[s]  <= h;
        p_addr[s] <= a;
      end
      if (sof) begin
        m_px <= int'(sx); m_py <= int'(sy); m_flip <= flip;
      end
      if (rst_pulse) begin
        m_play <= 1; m_done <= 0; m_frame <= 0; m_tick <= 0;
      end else if (!m_play && !m_done) begin
        if (en) m_play <= 1;
      end else if (m_play && sof && en) begin
        if (m_tick == FT - 1) begin
          m_tick <= 0;
          if (m_frame < NF - 1) m_frame <= m_frame + 1;
          else if (loopm) m_frame <= 0;
          else begin
            m_done <= 1; m_play <= 0;
          end
        end else begin
          m_tick <= m_tick + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    bit h;
    int a;
    if (chk_en) begin
      geom(0, h, a);
      check("model_addr0", 32'(addr0), a);
      geom(1, h, a);
      check("model_addr1", 32'(addr1), a);
      check("model_req0", 32'(req0), 32'(e_req[0]));
      check("model_rgb0", 32'(rgb0), 32'(e_rgb[0]));
      check("model_req1", 32'(req1), 32'(e_req[1]));
      check("model_rgb1", 32'(rgb1), 32'(e_rgb[1]));
      check("model_frame0", 32'(fi0), m_frame);
      check("model_frame1", 32'(fi1), m_frame);
      check("model_done0", 32'(done0), 32'(m_done));
      check("model_done1", 32'(done1), 32'(m_done));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_sof();
    sof = 1'b1; step(); sof = 1'b0; step();
  endtask

  task automatic place(input int px, input int py, input bit f);
    sx = 11'(px); sy = 11'(py); flip = f;
    pulse_sof();
  endtask

  // Drive one coordinate, check its address now and its pixel two edges later.
  task automatic pix(input int px, input int py, input int ea0, input int er0,
                     input int ergb0, input int ea1);
    x = 11'(px); y = 11'(py);
    #1;
    check("lit_addr0", 32'(addr0), ea0);
    check("lit_addr1", 32'(addr1), ea1);
    step(); step();
    check("lit_req0", 32'(req0), er0);
    check("lit_rgb0", 32'(rgb0), ergb0);
  endtask

  task automatic sofs(input int n);
    for (int i = 0; i < n; i++) pulse_sof();
  endtask

  initial begin
    repeat (3) step();
    check("rst_req", 32'(req0), 0);
    check("rst_rgb", 32'(rgb0), 0);
    check("rst_frame", 32'(fi0), 0);
    check("rst_done", 32'(done0), 0);
    chk_en = 1'b1;
    RESETn = 1'b1;
    step();

    // Basic box, right edge, transparency, scaled offset
    place(100, 50, 0);
    pix(100, 50, 0, 1, 8'h01, 0);
    pix(131, 50, 31, 1, 8'h20, 15);
    pix(132, 50, 0, 0, 8'h00, 16);
    pix(105, 50, 5, 0, 8'hFF, 2);
    pix(127, 50, 27, 1, 8'h1C, 13);
    pix(103, 51, 35, 1, 8'h24, 1);
    // Horizontal flip
    place(100, 50, 1);
    pix(100, 50, 31, 1, 8'h20, 31);
    pix(131, 50, 0, 1, 8'h01, 16);
    // Right screen edge: no wrap-around hits at small X
    place(2030, 50, 0);
    pix(10, 50, 0, 0, 8'h00, 0);
    pix(2040, 50, 10, 1, 8'h0B, 5);
    pix(2047, 81, 1009, 1, 8'h0A, 488);
    // Mid-frame position change takes effect only at the next frame start
    place(100, 50, 0);
    sx = 11'd300;
    pix(100, 50, 0, 1, 8'h01, 0);
    pulse_sof();
    pix(100, 50, 0, 0, 8'h00, 0);
    pix(301, 50, 1, 1, 8'h02, 0);

    // Looping animation
    place(100, 50, 0);
    en = 1'b1; loopm = 1'b1;
    step();
    sofs(8);  check("loop_f1", 32'(fi0), 1);
    sofs(8);  check("loop_f2", 32'(fi0), 2);
    pix(100, 50, 2048, 1, 8'h31, 2048);
    sofs(8);  check("loop_f3", 32'(fi0), 3);
    sofs(8);  check("loop_f0", 32'(fi0), 0);
    // One-shot
    loopm = 1'b0;
    sofs(24); check("shot_f3", 32'(fi0), 3);
    check("shot_notdone", 32'(done0), 0);
    sofs(8);  check("shot_hold", 32'(fi0), 3);
    check("shot_done", 32'(done0), 1);
    sofs(8);  check("done_hold", 32'(fi0), 3);
    // Restart coincident with start of frame
    rst_pulse = 1'b1; sof = 1'b1; step(); rst_pulse = 1'b0; sof = 1'b0; step();
    check("restart_f0", 32'(fi0), 0);
    check("restart_done", 32'(done0), 0);
    sofs(7);  check("restart_tick0", 32'(fi0), 0);
    sofs(1);  check("restart_f1", 32'(fi0), 1);
    // Pause
    en = 1'b0;
    sofs(16); check("pause_hold", 32'(fi0), 1);
    en = 1'b1;
    sofs(3);

    // Asynchronous reset mid-stream
    pix(100, 50, 1024, 1, 8'h19, 1024);
    #2 RESETn = 1'b0;
    #1;
    check("arst_req", 32'(req0), 0);
    check("arst_rgb", 32'(rgb0), 0);
    check("arst_frame", 32'(fi0), 0);
    check("arst_done", 32'(done0), 0);
    step(); step();
    RESETn = 1'b1;
    step();
    pix(0, 0, 0, 1, 8'h01, 0);
    pix(40, 0, 0, 0, 8'h00, 20);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
